// File: rtl/icache_direct_mapped_pkg.sv
// Shared constants, FSM state type and word-select helper for the
// direct-mapped instruction cache.
package icache_direct_mapped_pkg;

   localparam int LINE_W     = 128;
   localparam int WORD_W     = 32;
   localparam int MEM_ADDR_W = 28;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REFILL = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // Word 0 sits in the low 32 bits of a line, word 3 in the top 32 bits.
   function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        off);
      logic [WORD_W-1:0] w;
      case (off)
         2'd0:    w = line[31:0];
         2'd1:    w = line[63:32];
         2'd2:    w = line[95:64];
         2'd3:    w = line[127:96];
         default: w = line[31:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/icache_direct_mapped_line_array.sv
// Valid/tag/data storage for the instruction cache: one write port used by
// refill and one combinational read port used by the hit check.
module icache_direct_mapped_line_array
   import icache_direct_mapped_pkg::*;
#(
   parameter int NUM_LINES = 8,
   parameter int IDX_W     = 3,
   parameter int TAG_W     = 25
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [TAG_W-1:0]  wtag,
   input  logic [LINE_W-1:0] wline,
   input  logic [IDX_W-1:0]  ridx,
   output logic              rvalid,
   output logic [TAG_W-1:0]  rtag,
   output logic [LINE_W-1:0] rline
);

   logic [NUM_LINES-1:0] valid_r;
   logic [TAG_W-1:0]     tag_r  [NUM_LINES];
   logic [LINE_W-1:0]    data_r [NUM_LINES];

   // Valid bits: cleared by reset, set when a refill installs a line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= {NUM_LINES{1'b0}};
      end else if (we) begin
         valid_r[widx] <= 1'b1;
      end
   end

   // Tag and data payload; only meaningful behind a valid bit, so no reset.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_r[widx]  <= wtag;
         data_r[widx] <= wline;
      end
   end

   assign rvalid = valid_r[ridx];
   assign rtag   = tag_r[ridx];
   assign rline  = data_r[ridx];

endmodule

// File: rtl/icache_direct_mapped.sv
// Read-only direct-mapped instruction cache: zero-latency hits, stalls the
// fetch stage through a one-line refill from 128-bit instruction memory.
module icache_direct_mapped
   import icache_direct_mapped_pkg::*;
#(
   parameter int NUM_LINES = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  proc_read,
   input  logic                  proc_write,
   input  logic [29:0]           proc_addr,
   input  logic [WORD_W-1:0]     proc_wdata,
   output logic                  proc_stall,
   output logic [WORD_W-1:0]     proc_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0]     mem_wdata,
   input  logic [LINE_W-1:0]     mem_rdata,
   input  logic                  mem_ready
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = MEM_ADDR_W - IDX_W;

   state_t            state_r;
   state_t            state_next_s;
   logic              mem_read_r;
   logic [IDX_W-1:0]  idx_s;
   logic [TAG_W-1:0]  tag_s;
   logic [1:0]        off_s;
   logic              line_valid_s;
   logic [TAG_W-1:0]  line_tag_s;
   logic [LINE_W-1:0] line_data_s;
   logic              req_s;
   logic              hit_s;
   logic              fill_s;
   logic              rdata_sel_s;
   logic              unused_s;

   assign off_s = proc_addr[1:0];
   assign idx_s = proc_addr[IDX_W+1:2];
   assign tag_s = proc_addr[29:IDX_W+2];

   // A write strobe turns the cycle into a non-request for this read-only cache.
   assign req_s = proc_read & ~proc_write;
   assign hit_s = line_valid_s & (line_tag_s == tag_s);

   icache_direct_mapped_line_array #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_lines (
      .clk    (clk),
      .rst    (rst),
      .we     (fill_s),
      .widx   (idx_s),
      .wtag   (tag_s),
      .wline  (mem_rdata),
      .ridx   (idx_s),
      .rvalid (line_valid_s),
      .rtag   (line_tag_s),
      .rline  (line_data_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state, stall and fill strobe; S_DONE keeps mem_ready off the stall path.
   always_comb begin
      state_next_s = state_r;
      proc_stall   = 1'b0;
      fill_s       = 1'b0;
      rdata_sel_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (req_s && !hit_s) begin
               proc_stall   = 1'b1;
               state_next_s = S_REFILL;
            end else if (req_s) begin
               rdata_sel_s  = 1'b1;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_REFILL: begin
            proc_stall = 1'b1;
            if (mem_ready) begin
               fill_s       = 1'b1;
               state_next_s = S_DONE;
            end else begin
               state_next_s = S_REFILL;
            end
         end
         S_DONE: begin
            rdata_sel_s  = 1'b1;
            state_next_s = S_IDLE;
         end
         default: begin
            state_next_s = S_IDLE;
         end
      endcase
   end

   // Memory request follows the state we are about to be in, so it rises on the first refill cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_read_r <= 1'b0;
      end else begin
         mem_read_r <= (state_next_s == S_REFILL);
      end
   end

   assign mem_read   = mem_read_r;
   assign mem_addr   = proc_addr[29:2];
   assign mem_write  = 1'b0;
   assign mem_wdata  = {LINE_W{1'b0}};
   assign proc_rdata = rdata_sel_s ? word_sel(line_data_s, off_s) : {WORD_W{1'b0}};
   assign unused_s   = ^proc_wdata;

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed plus randomized bench for icache_direct_mapped, checked against a
// line-level model of valid/tag/data with a synthetic instruction memory.
module tb_icache_direct_mapped;

   logic         clk = 1'b0;
   logic         rst;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   int vectors     = 0;
   int miscompares = 0;

   logic         ref_valid [8];
   logic [24:0]  ref_tag   [8];
   logic [127:0] ref_line  [8];

   always #5 clk = ~clk;

   icache_direct_mapped #(.NUM_LINES(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_stall (proc_stall),
      .proc_rdata (proc_rdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   function automatic logic [127:0] mem_line(input logic [27:0] la);
      if (la == 28'd1)
         return {32'h4, 32'h3, 32'h2, 32'h1};
      return {la, 2'd3, 2'b10, la, 2'd2, 2'b10, la, 2'd1, 2'b10, la, 2'd0, 2'b10};
   endfunction

   function automatic logic [31:0] word_of(input logic [127:0] l, input logic [1:0] off);
      return l[int'(off)*32 +: 32];
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
   endtask

   // One fetch: hit completes in the request cycle, miss walks detect/refill/done.
   task automatic fetch(input logic [29:0] a, input int lat, input bit drop);
      int          idx;
      logic [24:0] t;
      logic [127:0] l;
      int          stalls;
      idx    = int'(a[4:2]);
      t      = a[29:5];
      l      = mem_line(a[29:2]);
      stalls = 0;
      proc_read = 1'b1;
      proc_addr = a;
      @(negedge clk);
      if (ref_valid[idx] && ref_tag[idx] == t) begin
         chk("hit_stall", proc_stall, 0);
         chk("hit_rdata", proc_rdata, word_of(ref_line[idx], a[1:0]));
         chk("hit_mem_read", mem_read, 0);
         next_cycle();
      end else begin
         chk("detect_stall", proc_stall, 1);
         chk("detect_mem_read", mem_read, 0);
         if (proc_stall === 1'b1) stalls++;
         next_cycle();
         for (int n = 1; n <= lat; n++) begin
            if (n == lat) begin
               mem_ready = 1'b1;
               mem_rdata = l;
            end
            if (drop && n == 2) proc_read = 1'b0;
            @(negedge clk);
            chk("refill_stall", proc_stall, 1);
            chk("refill_mem_read", mem_read, 1);
            chk("refill_mem_addr", mem_addr, a[29:2]);
            if (proc_stall === 1'b1) stalls++;
            next_cycle();
            mem_ready = 1'b0;
            mem_rdata = 128'd0;
         end
         @(negedge clk);
         chk("done_stall", proc_stall, 0);
         chk("done_mem_read", mem_read, 0);
         chk("done_rdata", proc_rdata, word_of(l, a[1:0]));
         chk("miss_penalty", stalls, 1 + lat);
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = t;
         ref_line[idx]  = l;
         next_cycle();
      end
      proc_read = 1'b0;
   endtask

   initial begin
      logic [29:0] a;
      int          lat;
      bit          drop;

      rst        = 1'b1;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      proc_addr  = 30'd0;
      proc_wdata = 32'd0;
      mem_rdata  = 128'd0;
      mem_ready  = 1'b0;
      clear_model();
      #2;
      chk("rst_stall", proc_stall, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_rdata", proc_rdata, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      next_cycle();

      // Cold miss then hit sweep over the filled line.
      fetch(30'h4, 3, 1'b0);
      fetch(30'h4, 1, 1'b0);
      fetch(30'h5, 1, 1'b0);
      fetch(30'h6, 1, 1'b0);
      fetch(30'h7, 1, 1'b0);

      // Conflict eviction on index 1, then the original line misses again.
      fetch(30'h24, 2, 1'b0);
      chk("evict_model", ref_tag[1], 25'd1);
      fetch(30'h04, 1, 1'b0);

      // Stray mem_ready while idle must not disturb the array.
      mem_ready = 1'b1;
      mem_rdata = {4{32'hDEADBEEF}};
      @(negedge clk);
      chk("stray_idle_mem_read", mem_read, 0);
      next_cycle();
      mem_ready = 1'b0;
      fetch(30'h5, 1, 1'b0);

      // Reset two cycles into refill, then a stray mem_ready.
      proc_read = 1'b1;
      proc_addr = 30'h48;
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("pre_rst_mem_read", mem_read, 1);
      next_cycle();
      rst       = 1'b1;
      proc_read = 1'b0;
      #1;
      chk("midrst_mem_read", mem_read, 0);
      chk("midrst_stall", proc_stall, 0);
      clear_model();
      next_cycle();
      rst       = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = mem_line(28'h12);
      @(negedge clk);
      chk("postrst_mem_read", mem_read, 0);
      chk("postrst_stall", proc_stall, 0);
      next_cycle();
      mem_ready = 1'b0;
      fetch(30'h48, 2, 1'b0);
      fetch(30'h4, 1, 1'b0);

      // proc_read dropped mid-refill still installs the line.
      fetch(30'h6C, 4, 1'b1);
      fetch(30'h6E, 1, 1'b0);

      // Write strobe is not a request.
      for (int i = 0; i < 4; i++) begin
         proc_write = 1'b1;
         proc_read  = 1'b0;
         proc_addr  = 30'($urandom);
         proc_wdata = $urandom;
         @(negedge clk);
         chk("wr_stall", proc_stall, 0);
         chk("wr_mem_read", mem_read, 0);
         chk("wr_mem_write", mem_write, 0);
         next_cycle();
      end
      proc_write = 1'b0;
      fetch(30'h6D, 1, 1'b0);

      // Randomized fetches over a small tag pool to force conflicts.
      for (int i = 0; i < 60; i++) begin
         a    = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         lat  = $urandom_range(1, 4);
         drop = (lat >= 2) && ($urandom_range(0, 3) == 0);
         fetch(a, lat, drop);
         if ($urandom_range(0, 2) == 0) next_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
